mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM pipeline stage that sits directly downstream of the EX/MEM latch and consumes its outputs.
- Holds a word-organised synchronous-read data memory and performs word, halfword and byte loads and stores; sub-word stores use a two-cycle read-modify-write.
- Resolves the branch decision and registers the MEM/WB pipeline fields feeding write-back.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W words of 32 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inAlu  in  32  ALU result; byte address for memory ops, pass-through value otherwise
- inDataRt  in  32  store data
- inAddEx  in  32  branch target
- inZeroAlu, inBranch  in  1  branch condition and branch enable
- inRegWrite, inMemRead, inMemWrite  in  1  control
- inMemtoReg  in  2  write-back select, passed through
- inMuxRtRd  in  5  destination register, passed through
- inLoadFlag  in  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu
- inStoreFlag  in  2  0=sw, 1=sh, 2=sb
- stall  out  1  upstream must hold its inputs and PC this cycle
- pcSrc  out  1  inBranch & inZeroAlu, combinational
- branchTarget  out  32  equals inAddEx, combinational
- wbReadData  out  32  load data, formatted per the registered load flag
- wbAlu  out  32  registered inAlu
- wbRegWrite  out  1, wbMemtoReg  out  2, wbMuxRtRd  out  5  registered control
- alignErr  out  1  sticky misalignment flag; exists only when ALIGN_CHECK_EN is defined

Behaviour:
- Reset: every MEM/WB register and wbReadData = 0; state = IDLE; stall = 0; alignErr = 0. Memory contents are not reset.
- Addressing: word index is inAlu[ADDR_W+1:2]; byte lane is inAlu[1:0]; little-endian (lane 0 = bits 7:0).
- FSM states: IDLE and MERGE.
- IDLE, no memory op or a load: MEM/WB registers capture the inputs at the edge. Memory read data arrives one cycle later, aligned with the MEM/WB outputs.
- Load formatting: the registered lane and load flag format wbReadData combinationally.
  - lh/lb sign-extend; lhu/lbu zero-extend.
  - lh selects lane 0 or 2 using addr[1].
- IDLE, memWrite with sw: the full word is written at the edge; no stall.
- IDLE, memWrite with sh or sb:
  - The word read is issued, and address, data and flag are latched.
  - stall = 1 and the FSM moves to MERGE.
  - MEM/WB captures a bubble (wbRegWrite = 0, other fields 0).
- MERGE:
  - Held inputs are ignored (no re-trigger); stall = 0.
  - The latched bytes are merged into the read word and the merged word is written.
  - MEM/WB captures the store's control; the FSM returns to IDLE.
- memRead and memWrite both asserted: the write path wins, the read is not formatted and wbReadData = 0.
- Misaligned access without the optional feature: the low address bits are ignored (lw/sw force lane 0; lh/sh use addr[1] only).
- Reset asserted in MERGE: the pending write is dropped and the FSM returns to IDLE.
- pcSrc is not gated by stall; the upstream unit owns that priority.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- When defined:
  - A lw/sw with addr[1:0] != 0, or a lh/lhu/sh with addr[0] = 1, suppresses the memory write and forces wbRegWrite = 0.
  - It sets alignErr, which stays set until reset.
- When undefined: the alignErr port is absent and the truncation rule above applies.

Decomposition:
- Package mem_stage_pkg holds the load flag encodings, store flag encodings, the FSM state enum, and the LANE_* constants.
- One sub-module, mem_byte_lane_unit, is combinational and does two jobs:
  - store merge: old word + data + flag + lane -> new word
  - load extract: word + flag + lane -> 32-bit result
- The parent holds the FSM, the RAM and the MEM/WB registers.

Test Plan:
- sw 0xDEADBEEF to 0x10, then lw from 0x10 -> wbReadData = 0xDEADBEEF one cycle after the load; stall stays 0.
- Word 0x10 = 0x11223344, sb 0xAA to 0x11 -> stall high for exactly 1 cycle; word becomes 0x1122AA44; lbu 0x11 -> 0x000000AA; lb 0x11 -> 0xFFFFFFAA.
- sh 0x8001 to 0x12 over 0x11223344 -> word becomes 0x80013344; lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
- inBranch = 1, inZeroAlu = 1, inAddEx = 0x40 -> pcSrc = 1 and branchTarget = 0x40 in the same cycle; with inZeroAlu = 0 -> pcSrc = 0.
- Drop rst_n during MERGE of an sb -> memory word unchanged, stall = 0, state = IDLE, wbRegWrite = 0 immediately.
- With ALIGN_CHECK_EN defined: sw to 0x13 -> memory unchanged and alignErr = 1 until reset. Without it: the write lands at word 0x10.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: load/store flags, byte lanes and FSM states.
package mem_stage_pkg;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LHU = 3'd2;
  localparam logic [2:0] LOAD_LB  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;

  localparam logic [1:0] STORE_SW = 2'd0;
  localparam logic [1:0] STORE_SH = 2'd1;
  localparam logic [1:0] STORE_SB = 2'd2;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  typedef enum logic {StIdle, StMerge} state_e;

  function automatic logic isSubWordStore(input logic [1:0] flag);
    return (flag == STORE_SH) || (flag == STORE_SB);
  endfunction

endpackage

// File: rtl/mem_byte_lane_unit.sv
// Combinational byte-lane logic: merges sub-word store data into an old word and
// extracts/extends sub-word load results (little-endian, lane 0 = bits 7:0).
module mem_byte_lane_unit
  import mem_stage_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  input  logic [1:0]  storeFlag,
  input  logic [1:0]  storeLane,
  input  logic [31:0] loadWord,
  input  logic [2:0]  loadFlag,
  input  logic [1:0]  loadLane,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    mergedWord = storeData;
    case (storeFlag)
      STORE_SH: begin
        mergedWord = storeLane[1] ? {storeData[15:0], oldWord[15:0]}
                                  : {oldWord[31:16], storeData[15:0]};
      end
      STORE_SB: begin
        mergedWord = oldWord;
        case (storeLane)
          LANE_0:  mergedWord[7:0]   = storeData[7:0];
          LANE_1:  mergedWord[15:8]  = storeData[7:0];
          LANE_2:  mergedWord[23:16] = storeData[7:0];
          LANE_3:  mergedWord[31:24] = storeData[7:0];
          default: mergedWord        = oldWord;
        endcase
      end
      default: mergedWord = storeData;
    endcase
  end

  // Halfword lane is chosen by addr[1] only; addr[0] is truncated.
  always_comb begin
    loadHalf = loadLane[1] ? loadWord[31:16] : loadWord[15:0];
    loadByte = loadWord[7:0];
    case (loadLane)
      LANE_1:  loadByte = loadWord[15:8];
      LANE_2:  loadByte = loadWord[23:16];
      LANE_3:  loadByte = loadWord[31:24];
      default: loadByte = loadWord[7:0];
    endcase
    case (loadFlag)
      LOAD_LW:  loadData = loadWord;
      LOAD_LH:  loadData = {{16{loadHalf[15]}}, loadHalf};
      LOAD_LHU: loadData = {16'h0000, loadHalf};
      LOAD_LB:  loadData = {{24{loadByte[7]}}, loadByte};
      LOAD_LBU: loadData = {24'h000000, loadByte};
      default:  loadData = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data RAM with word/half/byte access (sub-word stores via a
// two-cycle read-modify-write), branch resolve and MEM/WB registers. Option: ALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inAlu,
  input  logic [31:0] inDataRt,
  input  logic [31:0] inAddEx,
  input  logic        inZeroAlu,
  input  logic        inBranch,
  input  logic        inRegWrite,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inMemtoReg,
  input  logic [4:0]  inMuxRtRd,
  input  logic [2:0]  inLoadFlag,
  input  logic [1:0]  inStoreFlag,
  output logic        stall,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic [31:0] wbReadData,
  output logic [31:0] wbAlu,
  output logic        wbRegWrite,
  output logic [1:0]  wbMemtoReg,
  output logic [4:0]  wbMuxRtRd
`ifdef ALIGN_CHECK_EN
  ,
  output logic        alignErr
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];

  state_e            state;
  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        lane;
  logic              misalign;
  logic              writeOk;
  logic              fullWrite;
  logic              startMerge;

  logic [ADDR_W-1:0] mergeIdx;
  logic [1:0]        mergeLane;
  logic [31:0]       mergeData;
  logic [1:0]        mergeFlag;
  logic [31:0]       mergeAlu;
  logic              mergeRegWrite;
  logic [1:0]        mergeMemtoReg;
  logic [4:0]        mergeRtRd;

  logic [31:0]       rdWord;
  logic [2:0]        loadFlagQ;
  logic [1:0]        laneQ;
  logic              readValidQ;
  logic [31:0]       mergedWord;
  logic [31:0]       loadData;

  assign wordIdx      = inAlu[ADDR_W+1:2];
  assign lane         = inAlu[1:0];
  assign pcSrc        = inBranch & inZeroAlu;
  assign branchTarget = inAddEx;

`ifdef ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (inMemWrite) begin
      case (inStoreFlag)
        STORE_SW: misalign = (lane != LANE_0);
        STORE_SH: misalign = lane[0];
        default:  misalign = 1'b0;
      endcase
    end else if (inMemRead) begin
      case (inLoadFlag)
        LOAD_LW:           misalign = (lane != LANE_0);
        LOAD_LH, LOAD_LHU: misalign = lane[0];
        default:           misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign writeOk    = ~misalign;
  assign fullWrite  = (state == StIdle) && inMemWrite && !isSubWordStore(inStoreFlag) && writeOk;
  assign startMerge = (state == StIdle) && inMemWrite && isSubWordStore(inStoreFlag) && writeOk;
  assign stall      = startMerge;

  // Read port always follows the live address; MERGE consumes the word read while stalled.
  always_ff @(posedge clk) begin
    rdWord <= mem[wordIdx];
    if (fullWrite) begin
      mem[wordIdx] <= inDataRt;
    end else if (state == StMerge) begin
      mem[mergeIdx] <= mergedWord;
    end
  end

  mem_byte_lane_unit u_lane (
    .oldWord   (rdWord),
    .storeData (mergeData),
    .storeFlag (mergeFlag),
    .storeLane (mergeLane),
    .loadWord  (rdWord),
    .loadFlag  (loadFlagQ),
    .loadLane  (laneQ),
    .mergedWord(mergedWord),
    .loadData  (loadData)
  );

  assign wbReadData = readValidQ ? loadData : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      wbAlu         <= '0;
      wbRegWrite    <= 1'b0;
      wbMemtoReg    <= '0;
      wbMuxRtRd     <= '0;
      loadFlagQ     <= '0;
      laneQ         <= '0;
      readValidQ    <= 1'b0;
      mergeIdx      <= '0;
      mergeLane     <= '0;
      mergeData     <= '0;
      mergeFlag     <= '0;
      mergeAlu      <= '0;
      mergeRegWrite <= 1'b0;
      mergeMemtoReg <= '0;
      mergeRtRd     <= '0;
`ifdef ALIGN_CHECK_EN
      alignErr      <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (startMerge) begin
            state         <= StMerge;
            mergeIdx      <= wordIdx;
            mergeLane     <= lane;
            mergeData     <= inDataRt;
            mergeFlag     <= inStoreFlag;
            mergeAlu      <= inAlu;
            mergeRegWrite <= inRegWrite;
            mergeMemtoReg <= inMemtoReg;
            mergeRtRd     <= inMuxRtRd;
            wbAlu         <= '0;
            wbRegWrite    <= 1'b0;
            wbMemtoReg    <= '0;
            wbMuxRtRd     <= '0;
            loadFlagQ     <= '0;
            laneQ         <= '0;
            readValidQ    <= 1'b0;
          end else begin
            wbAlu      <= inAlu;
            wbRegWrite <= inRegWrite & writeOk;
            wbMemtoReg <= inMemtoReg;
            wbMuxRtRd  <= inMuxRtRd;
            loadFlagQ  <= inLoadFlag;
            laneQ      <= lane;
            // A simultaneous write takes the cycle; its read is not formatted.
            readValidQ <= inMemRead & ~inMemWrite;
          end
        end
        StMerge: begin
          state      <= StIdle;
          wbAlu      <= mergeAlu;
          wbRegWrite <= mergeRegWrite;
          wbMemtoReg <= mergeMemtoReg;
          wbMuxRtRd  <= mergeRtRd;
          loadFlagQ  <= '0;
          laneQ      <= '0;
          readValidQ <= 1'b0;
        end
        default: state <= StIdle;
      endcase
`ifdef ALIGN_CHECK_EN
      if ((state == StIdle) && misalign && (inMemRead || inMemWrite)) begin
        alignErr <= 1'b1;
      end
`endif
    end
  end

endmodule
